// File: rtl/fp16_align_addsub.sv
// Front half of the half-precision add/subtract datapath: operand decode, iterative
// mantissa alignment, mantissa add/subtract, valid/ready hand-off to normalize.
module fp16_align_addsub #(
  parameter int BIG_SHIFT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        srd,
  output logic [4:0]  e5d,
  output logic [11:0] mfd,
  output logic        if_equal,
  output logic        add_sub,
  output logic [1:0]  if_zero
);

  localparam logic [4:0] BIG_W = 5'(BIG_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, ADD, HOLD} state_t;

  state_t state, state_nxt;

  logic [4:0]  exp_a, exp_b;
  logic [10:0] man_a, man_b;
  logic        sign_b_eff, eff_sub, b_larger, mag_equal, srd_dec;

  // Operands captured at accept; the flags wait here until the ADD cycle.
  logic [10:0] big_m_p0, small_m_p0;
  logic [4:0]  cnt_p0;
  logic [4:0]  e5_p0;
  logic        srd_p0, eq_p0, sub_p0;
  logic [1:0]  zero_p0;
  logic [11:0] sum_p0;

  assign exp_a      = a[14:10];
  assign exp_b      = b[14:10];
  assign man_a      = {(exp_a != 5'd0), a[9:0]};
  assign man_b      = {(exp_b != 5'd0), b[9:0]};
  assign sign_b_eff = b[15] ^ op_sub;
  assign eff_sub    = a[15] ^ sign_b_eff;
  assign b_larger   = b[14:0] > a[14:0];
  assign mag_equal  = a[14:0] == b[14:0];
  // x - x yields +0 regardless of operand signs.
  assign srd_dec    = (eff_sub && mag_equal) ? 1'b0 : (b_larger ? sign_b_eff : a[15]);

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = SHIFT;
      SHIFT: if (cnt_p0 == 5'd0) state_nxt = ADD;
      ADD:   state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p0 <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid)
        cnt_p0 <= b_larger ? (exp_b - exp_a) : (exp_a - exp_b);
      else if (state == SHIFT && cnt_p0 != 5'd0)
        cnt_p0 <= (cnt_p0 >= BIG_W) ? 5'd0 : (cnt_p0 - 5'd1);
    end
  end

  // Alignment: one bit per cycle, or a single-cycle flush for large distances.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      big_m_p0   <= b_larger ? man_b : man_a;
      small_m_p0 <= b_larger ? man_a : man_b;
      e5_p0      <= b_larger ? exp_b : exp_a;
      srd_p0     <= srd_dec;
      eq_p0      <= mag_equal;
      sub_p0     <= eff_sub;
      zero_p0    <= {(a[14:0] == 15'd0), (b[14:0] == 15'd0)};
    end else if (state == SHIFT && cnt_p0 != 5'd0) begin
      small_m_p0 <= (cnt_p0 >= BIG_W) ? 11'd0 : (small_m_p0 >> 1);
    end
  end

  assign sum_p0 = sub_p0 ? {1'b0, big_m_p0 - small_m_p0}
                         : ({1'b0, big_m_p0} + {1'b0, small_m_p0});

  // Result registers: updated only on ADD, held through HOLD and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      srd       <= 1'b0;
      e5d       <= 5'd0;
      mfd       <= 12'd0;
      if_equal  <= 1'b0;
      add_sub   <= 1'b0;
      if_zero   <= 2'b00;
    end else if (state == ADD) begin
      out_valid <= 1'b1;
      srd       <= srd_p0;
      e5d       <= e5_p0;
      mfd       <= sum_p0;
      if_equal  <= eq_p0;
      add_sub   <= sub_p0;
      if_zero   <= zero_p0;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp16_align_addsub.sv
// Directed bench for fp16_align_addsub: driver pushes expected results into a queue,
// a monitor pops and compares on each new result, including accept-to-valid latency.
`timescale 1ns/1ps
module tb_fp16_align_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        srd;
  logic [4:0]  e5d;
  logic [11:0] mfd;
  logic        if_equal;
  logic        add_sub;
  logic [1:0]  if_zero;

  fp16_align_addsub #(.BIG_SHIFT(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .srd(srd), .e5d(e5d), .mfd(mfd), .if_equal(if_equal), .add_sub(add_sub),
    .if_zero(if_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        srd;
    logic [4:0]  e5d;
    logic [11:0] mfd;
    logic        eq;
    logic        as;
    logic [1:0]  z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [4:0] e, input logic [11:0] m,
                              input logic eq, input logic as, input logic [1:0] z,
                              input int lat);
    exp_t r;
    r.srd = s; r.e5d = e; r.mfd = m; r.eq = eq; r.as = as; r.z = z;
    r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // Monitor: compare each freshly presented result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency",  cyc - e.acc, e.lat);
        chk("mfd",      int'(mfd), int'(e.mfd));
        chk("e5d",      int'(e5d), int'(e.e5d));
        chk("srd",      int'(srd), int'(e.srd));
        chk("if_equal", int'(if_equal), int'(e.eq));
        chk("add_sub",  int'(add_sub), int'(e.as));
        chk("if_zero",  int'(if_zero), int'(e.z));
      end
    end
    prev_v = out_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input exp_t e, input bit push);
    wait_ready();
    @(negedge clk);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (push) q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_outputs", int'({srd, e5d, mfd, if_equal, add_sub, if_zero}), 0);

    issue(16'h3C00, 16'h3C00, 1'b0, mk(0, 15, 12'h800, 1, 0, 2'b00, 2), 1);
    issue(16'h3C00, 16'h3800, 1'b0, mk(0, 15, 12'h600, 0, 0, 2'b00, 3), 1);
    issue(16'h3C00, 16'h3C00, 1'b1, mk(0, 15, 12'h000, 1, 1, 2'b00, 2), 1);
    issue(16'h3800, 16'h3C00, 1'b1, mk(1, 15, 12'h200, 0, 1, 2'b00, 3), 1);
    issue(16'h0000, 16'h8000, 1'b1, mk(0, 0,  12'h000, 1, 0, 2'b11, 2), 1);
    issue(16'h3E00, 16'hBC00, 1'b0, mk(0, 15, 12'h200, 0, 1, 2'b00, 2), 1);
    issue(16'h6400, 16'h3C00, 1'b0, mk(0, 25, 12'h401, 0, 0, 2'b00, 12), 1);
    issue(16'h6800, 16'h3C00, 1'b0, mk(0, 26, 12'h400, 0, 0, 2'b00, 13), 1);
    issue(16'h3C00, 16'h6C00, 1'b0, mk(0, 27, 12'h400, 0, 0, 2'b00, 3), 1);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(16'h7800, 16'h3C00, 1'b0, mk(0, 30, 12'h400, 0, 0, 2'b00, 3), 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_mfd", int'(mfd), 12'h400);
      chk("hold_e5d", int'(e5d), 30);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    chk("idle_mfd_stable", int'(mfd), 12'h400);

    // Reset in the middle of a diff-10 alignment.
    issue(16'h6400, 16'h3C00, 1'b0, mk(0, 0, 12'h000, 0, 0, 2'b00, 0), 0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", int'(in_ready), 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_outputs", int'({srd, e5d, mfd, if_equal, add_sub, if_zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h6400, 16'h3C00, 1'b1, mk(0, 25, 12'h3FF, 0, 1, 2'b00, 12), 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", total);
    $fatal(1, "timeout");
  end

endmodule
